// File: rtl/tail_light_sequencer_if.sv
// Lamp request and status bundle for the tail light sequencer.
// The requester side drives levels; the sequencer side reports mode and lamps.
interface tail_light_sequencer_if;
    logic       REQ_HAZARD;
    logic       REQ_LEFT;
    logic       REQ_RIGHT;
    logic [2:0] CurrentState;
    logic [2:0] LEDS_L;
    logic [2:0] LEDS_R;
    logic       BUSY;

    modport master (
        output REQ_HAZARD,
        output REQ_LEFT,
        output REQ_RIGHT,
        input  CurrentState,
        input  LEDS_L,
        input  LEDS_R,
        input  BUSY
    );

    modport slave (
        input  REQ_HAZARD,
        input  REQ_LEFT,
        input  REQ_RIGHT,
        output CurrentState,
        output LEDS_L,
        output LEDS_R,
        output BUSY
    );
endinterface

// File: rtl/tail_light_sequencer.sv
// Tail light sequencer: synchronized requests drive a {mode, step} FSM
// advanced by a prescaler tick; all outputs come straight from flops.
module tail_light_sequencer #(
    parameter int unsigned TICK_DIV = 25
) (
    input logic                    CLK,
    input logic                    RESET_N,
    tail_light_sequencer_if.slave  bus
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    localparam logic [1:0] M_IDLE  = 2'd0;
    localparam logic [1:0] M_HAZ   = 2'd1;
    localparam logic [1:0] M_LEFT  = 2'd2;
    localparam logic [1:0] M_RIGHT = 2'd3;

    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [1:0]    step_q, step_d;
    logic [2:0]    state_q, state_d;
    logic [2:0]    leds_l_q, leds_l_d;
    logic [2:0]    leds_r_q, leds_r_d;
    logic          busy_q, busy_d;

    logic          tick;
    logic          hz_s, l_s, r_s;
    logic [1:0]    eff;
    logic [2:0]    pat;

    assign hz_s = sync2_q[2];
    assign l_s  = sync2_q[1];
    assign r_s  = sync2_q[0];
    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        sync1_d = {bus.REQ_HAZARD, bus.REQ_LEFT, bus.REQ_RIGHT};
        sync2_d = sync1_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
    end

    // M_IDLE doubles as the "no request" code
    always_comb begin
        if (hz_s || (l_s && r_s)) begin
            eff = M_HAZ;
        end else if (l_s) begin
            eff = M_LEFT;
        end else if (r_s) begin
            eff = M_RIGHT;
        end else begin
            eff = M_IDLE;
        end
    end

    always_comb begin
        mode_d = mode_q;
        step_d = step_q;
        if (tick) begin
            if (eff == M_HAZ && mode_q != M_HAZ) begin
                mode_d = M_HAZ;
                step_d = 2'd1;
            end else if (mode_q == M_IDLE || step_q == 2'd0) begin
                mode_d = eff;
                step_d = (eff == M_IDLE) ? 2'd0 : 2'd1;
            end else if (mode_q == M_HAZ) begin
                step_d = 2'd0;
            end else begin
                step_d = step_q + 2'd1;
            end
        end
    end

    // Decode from next state so every output is a plain flop
    always_comb begin
        pat      = 3'b000;
        leds_l_d = 3'b000;
        leds_r_d = 3'b000;
        unique case (step_d)
            2'd0: pat = 3'b000;
            2'd1: pat = 3'b001;
            2'd2: pat = 3'b011;
            2'd3: pat = 3'b111;
        endcase
        unique case (mode_d)
            M_IDLE:  ;
            M_HAZ: begin
                leds_l_d = {3{step_d == 2'd1}};
                leds_r_d = {3{step_d == 2'd1}};
            end
            M_LEFT:  leds_l_d = pat;
            M_RIGHT: leds_r_d = pat;
        endcase
        state_d = {1'b0, mode_d};
        busy_d  = (mode_d != M_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q    <= '0;
            mode_q   <= M_IDLE;
            step_q   <= 2'd0;
            state_q  <= '0;
            leds_l_q <= '0;
            leds_r_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            step_q   <= step_d;
            state_q  <= state_d;
            leds_l_q <= leds_l_d;
            leds_r_q <= leds_r_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.CurrentState = state_q;
    assign bus.LEDS_L       = leds_l_q;
    assign bus.LEDS_R       = leds_r_q;
    assign bus.BUSY         = busy_q;

endmodule

// File: doc/tail_light_sequencer.md
TAIL_LIGHT_SEQUENCER -- requirements
Module: tail_light_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 25: the step period in CLK cycles; legal range 2 to 65535.
REQ-002 CLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 REQ_HAZARD  input  1  level request for hazard flashing; may be asynchronous to CLK.
REQ-005 REQ_LEFT  input  1  level request for the left turn sequence; may be asynchronous to CLK.
REQ-006 REQ_RIGHT  input  1  level request for the right turn sequence; may be asynchronous to CLK.
REQ-007 CurrentState  output  3  active mode: 000 idle, 001 hazard, 010 left, 011 right.
REQ-008 LEDS_L  output  3  left lamp bank; bit0 is the innermost lamp.
REQ-009 LEDS_R  output  3  right lamp bank; bit0 is the innermost lamp.
REQ-010 BUSY  output  1  high whenever CurrentState != 000.

Function
REQ-011 Each request SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized values (hz_s, l_s, r_s).
REQ-012 The prescaler counter SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be high for the one cycle in which the count equals TICK_DIV-1.
REQ-013 Counter width SHALL be ceil(log2(TICK_DIV)) bits, minimum 1; the counter SHALL never exceed TICK_DIV-1.
REQ-014 The FSM state SHALL be {mode, step}, with mode in IDLE/HAZ/LEFT/RIGHT and step in 0..3; it SHALL change only on cycles where tick is high.
REQ-015 Effective request SHALL be resolved in this order: HAZ if hz_s, or if l_s and r_s are both high; else LEFT if l_s; else RIGHT if r_s; else NONE.
REQ-016 Preemption: on a tick where the effective request is HAZ and mode != HAZ, the next state SHALL be HAZ, step 1, regardless of the current step.
REQ-017 From IDLE on a tick: if the effective request is not NONE, the next state SHALL be that mode with step 1; otherwise the FSM SHALL stay in IDLE, step 0.
REQ-018 LEFT and RIGHT SHALL advance step 1->2->3->0; they SHALL NOT be interrupted except by HAZ preemption.
REQ-019 HAZ SHALL advance step 1->0.
REQ-020 Step 0 in a non-IDLE mode is the dark boundary tick. On the next tick: if the effective request equals mode, go to step 1; if it is another non-NONE mode, switch to that mode at step 1; if it is NONE, go to IDLE, step 0.
REQ-021 LEFT LED pattern by step: 0->000, 1->001, 2->011, 3->111 on LEDS_L; LEDS_R SHALL be 000. RIGHT is the mirror image (pattern on LEDS_R, LEDS_L = 000).
REQ-022 HAZ LED pattern: step 1 -> both banks 111; step 0 -> both banks 000. IDLE -> both banks 000.
REQ-023 CurrentState, LEDS_L, LEDS_R and BUSY SHALL be decoded from registered state only and SHALL be glitch-free.
REQ-024 Latency: a request edge SHALL be seen by the FSM 2 cycles later and acted on at the first tick after that.
REQ-025 A request that pulses and drops between ticks SHALL be ignored; requests are not latched.

Reset
REQ-026 While RESET_N is low, without needing a clock edge: synchronizers 0, counter 0, mode IDLE, step 0, and all outputs 0.
REQ-027 After RESET_N rises, the first tick SHALL occur on the TICK_DIV-th rising edge of CLK.
REQ-028 Reset asserted mid-sequence SHALL abort the sequence immediately; no partial pattern SHALL resume after release.

Verification (TICK_DIV=4)
REQ-029 Reset, no requests for 40 cycles -> CurrentState 000, LEDS 000/000, BUSY 0 throughout.
REQ-030 REQ_LEFT held -> successive ticks give CurrentState 010 with LEDS_L 001, 011, 111, 000, 001...; LEDS_R stays 000; BUSY 1.
REQ-031 REQ_LEFT and REQ_RIGHT both held -> CurrentState 001; both banks alternate 111 / 000 on every tick.
REQ-032 LEFT at step 2, then REQ_HAZARD raised -> at the first tick after sync latency, CurrentState 001 and both banks 111.
REQ-033 LEFT at step 2, REQ_LEFT dropped and REQ_RIGHT raised -> LEDS_L goes 111 then 000, then CurrentState 011 with LEDS_R 001.
REQ-034 RESET_N pulled low during HAZ with CLK stopped -> all outputs 0 immediately; after release, first tick on the 4th CLK edge.
